// File: rtl/perf_counter_array_if.sv
// perf_counter_array_if: Avalon-MM slave bus and interrupt line of the performance counter array.
interface perf_counter_array_if #(
    parameter int AW = 4
);
    logic [AW-1:0] address;
    logic          begintransfer;
    logic          write;
    logic          read;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;
    modport master (output address, begintransfer, write, read, writedata, input readdata, irq);
    modport slave  (input address, begintransfer, write, read, writedata, output readdata, irq);
endinterface

// File: rtl/perf_counter_array.sv
// perf_counter_array: per-section time/event counters with coherent 64-bit reads over Avalon-MM.
// Define PERF_CNT_IRQ_EN to build the overflow interrupt (irq_en status bit and registered irq).
module perf_counter_array #(
    parameter int NUM_SECTIONS = 4,
    parameter int TIME_W       = 64,
    parameter int EVT_W        = 32
) (
    input logic clk,
    input logic reset_n,
    perf_counter_array_if.slave bus
);
    localparam int AW = $clog2(NUM_SECTIONS) + 2;
    localparam int SW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam int HW = TIME_W - 32;

    logic                    wstb, rstb, sec_ok, global_enable, global_reset;
    logic [1:0]              word;
    logic [AW-1:0]           sec;
    logic [SW-1:0]           idx;
    logic [NUM_SECTIONS-1:0] enable, tovf, eovf, irq_en, go_v, stop_v;
    logic [31:0]             time_lo [NUM_SECTIONS];
    logic [31:0]             shadow_x [NUM_SECTIONS];
    logic [31:0]             event_x [NUM_SECTIONS];
    logic [31:0]             rd_mux, rd_q;
    logic                    unused_wd;

    // write wins when both requests arrive together
    assign wstb          = bus.write & bus.begintransfer;
    assign rstb          = bus.read & bus.begintransfer & ~bus.write;
    assign word          = bus.address[1:0];
    assign sec           = bus.address >> 2;
    assign idx           = sec[SW-1:0];
    assign sec_ok        = sec < AW'(NUM_SECTIONS);
    assign global_enable = enable[0] | go_v[0];
    assign global_reset  = stop_v[0] & bus.writedata[0];

    for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_sec
        logic [TIME_W-1:0] time_q;
        logic [EVT_W-1:0]  event_q;
        logic [HW-1:0]     shadow_q;
        logic              en_q, tovf_q, eovf_q, hit, stop, go, stat, tick, bump;
        assign hit  = sec == AW'(s);
        assign stop = wstb & hit & (word == 2'd0);
        assign go   = wstb & hit & (word == 2'd1);
        assign stat = wstb & hit & (word == 2'd3);
        assign tick = en_q & global_enable;
        assign bump = go & global_enable;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                time_q  <= '0;
                event_q <= '0;
                en_q    <= 1'b0;
                tovf_q  <= 1'b0;
                eovf_q  <= 1'b0;
            end else if (global_reset) begin
                time_q  <= '0;
                event_q <= '0;
                en_q    <= 1'b0;
                tovf_q  <= 1'b0;
                eovf_q  <= 1'b0;
            end else begin
                en_q    <= stop ? 1'b0 : go ? 1'b1 : en_q;
                time_q  <= tick ? time_q + TIME_W'(1) : time_q;
                event_q <= bump ? event_q + EVT_W'(1) : event_q;
                // a wrap in the same cycle as a clear keeps the sticky bit set
                tovf_q  <= (tick & (&time_q)) | (tovf_q & ~(stat & bus.writedata[1]));
                eovf_q  <= (bump & (&event_q)) | (eovf_q & ~(stat & bus.writedata[2]));
            end
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                shadow_q <= '0;
            else if (rstb & hit & (word == 2'd0))
                shadow_q <= time_q[TIME_W-1:32];
        end
`ifdef PERF_CNT_IRQ_EN
        logic ie_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                ie_q <= 1'b0;
            else if (stat)
                ie_q <= bus.writedata[8];
        end
        assign irq_en[s] = ie_q;
`else
        assign irq_en[s] = 1'b0;
`endif
        assign enable[s]   = en_q;
        assign tovf[s]     = tovf_q;
        assign eovf[s]     = eovf_q;
        assign go_v[s]     = go;
        assign stop_v[s]   = stop;
        assign time_lo[s]  = time_q[31:0];
        assign shadow_x[s] = 32'(shadow_q);
        assign event_x[s]  = 32'(event_q);
    end

    always_comb begin
        rd_mux = '0;
        if (sec_ok)
            rd_mux = (word == 2'd0) ? time_lo[idx] :
                     (word == 2'd1) ? shadow_x[idx] :
                     (word == 2'd2) ? event_x[idx] :
                     {23'b0, irq_en[idx], 5'b0, eovf[idx], tovf[idx], enable[idx]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_q <= '0;
        else
            rd_q <= rd_mux;
    end
    assign bus.readdata = rd_q;

`ifdef PERF_CNT_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq_q <= 1'b0;
        else
            irq_q <= |(irq_en & (tovf | eovf));
    end
    assign bus.irq   = irq_q;
    assign unused_wd = &{1'b0, bus.writedata[31:9], bus.writedata[7:3]};
`else
    assign bus.irq   = 1'b0;
    assign unused_wd = &{1'b0, bus.writedata[31:3]};
`endif
endmodule

// File: tb/tb_perf_counter_array.sv
// tb_perf_counter_array: directed checks of three counter-array builds (default, 40-bit time, 2-bit events/3 sections).
module tb_perf_counter_array;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   errs = 0;
    int   checks = 0;
`ifdef PERF_CNT_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif
    localparam logic [31:0] IE = IRQ ? 32'h100 : 32'h0;

    always #5 clk = ~clk;

    perf_counter_array_if #(.AW(4)) b0 ();
    perf_counter_array_if #(.AW(4)) b1 ();
    perf_counter_array_if #(.AW(4)) b2 ();

    perf_counter_array #(.NUM_SECTIONS(4)) dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    perf_counter_array #(.NUM_SECTIONS(4), .TIME_W(40)) dut40 (.clk(clk), .reset_n(reset_n), .bus(b1));
    perf_counter_array #(.NUM_SECTIONS(3), .EVT_W(2)) dute (.clk(clk), .reset_n(reset_n), .bus(b2));

    task automatic drive(input int d, input logic bt, input logic w, input logic r,
                         input logic [3:0] a, input logic [31:0] wd);
        if (d == 0) begin
            b0.begintransfer = bt; b0.write = w; b0.read = r; b0.address = a; b0.writedata = wd;
        end else if (d == 1) begin
            b1.begintransfer = bt; b1.write = w; b1.read = r; b1.address = a; b1.writedata = wd;
        end else begin
            b2.begintransfer = bt; b2.write = w; b2.read = r; b2.address = a; b2.writedata = wd;
        end
    endtask

    function automatic logic [31:0] rdata(input int d);
        return (d == 0) ? b0.readdata : (d == 1) ? b1.readdata : b2.readdata;
    endfunction

    function automatic logic irqv(input int d);
        return (d == 0) ? b0.irq : (d == 1) ? b1.irq : b2.irq;
    endfunction

    task automatic op(input int d, input logic w, input logic r, input logic [3:0] a,
                      input logic [31:0] wd, output logic [31:0] q);
        @(negedge clk);
        drive(d, 1'b1, w, r, a, wd);
        @(posedge clk);
        #1;
        q = rdata(d);
        drive(d, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic wr(input int d, input logic [3:0] a, input logic [31:0] wd);
        logic [31:0] q;
        op(d, 1'b1, 1'b0, a, wd, q);
    endtask

    task automatic rd(input int d, input logic [3:0] a, output logic [31:0] q);
        op(d, 1'b0, 1'b1, a, 32'h0, q);
    endtask

    task automatic test_reset;
        logic [31:0] q;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1 reset_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++; if (rdata(d) !== 32'h0) begin errs++; $display("FAIL reset_rdata%0d: got %h want 0", d, rdata(d)); end
            checks++; if (irqv(d) !== 1'b0) begin errs++; $display("FAIL reset_irq%0d: got %b want 0", d, irqv(d)); end
        end
        @(negedge clk) reset_n = 1'b1;
        rd(0, 4'h3, q);
        checks++; if (q !== 32'h0) begin errs++; $display("FAIL reset_status: got %h want 0", q); end
        rd(0, 4'h0, q);
        checks++; if (q !== 32'h0) begin errs++; $display("FAIL reset_time: got %h want 0", q); end
    endtask

    task automatic test_count;
        logic [31:0] q;
        wr(0, 4'h1, 32'h0);
        repeat (100) @(posedge clk);
        wr(0, 4'h0, 32'h0);
        rd(0, 4'h0, q);
        checks++; if (q !== 32'd101) begin errs++; $display("FAIL count_time: got %0d want 101", q); end
        rd(0, 4'h2, q);
        checks++; if (q !== 32'd1) begin errs++; $display("FAIL count_event: got %0d want 1", q); end
        rd(0, 4'h1, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL count_high: got %h want 0", q); end
        rd(0, 4'h3, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL count_status: got %h want 0", q); end
    endtask

    task automatic test_gate;
        logic [31:0] q;
        wr(0, 4'h5, 32'h0);
        repeat (10) @(posedge clk);
        rd(0, 4'h4, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL gate_time1: got %0d want 0", q); end
        rd(0, 4'h6, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL gate_event1: got %0d want 0", q); end
        rd(0, 4'h7, q);
        checks++; if (q !== 32'h1) begin errs++; $display("FAIL gate_status1: got %h want 1", q); end
        wr(0, 4'h1, 32'h0);
        wr(0, 4'h5, 32'h0);
        rd(0, 4'h0, q);
        checks++; if (q !== 32'd102) begin errs++; $display("FAIL gate_time0: got %0d want 102", q); end
        rd(0, 4'h4, q);
        checks++; if (q !== 32'd3) begin errs++; $display("FAIL gate_time1_run: got %0d want 3", q); end
        rd(0, 4'h6, q);
        checks++; if (q !== 32'd1) begin errs++; $display("FAIL gate_event1_run: got %0d want 1", q); end
    endtask

    task automatic test_global_reset;
        logic [31:0] q;
        wr(0, 4'h7, 32'h100);
        wr(0, 4'h0, 32'h1);
        rd(0, 4'h0, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL grst_time0: got %0d want 0", q); end
        rd(0, 4'h4, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL grst_time1: got %0d want 0", q); end
        rd(0, 4'h2, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL grst_event0: got %0d want 0", q); end
        rd(0, 4'h6, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL grst_event1: got %0d want 0", q); end
        rd(0, 4'h3, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL grst_status0: got %h want 0", q); end
        rd(0, 4'h7, q);
        checks++; if (q !== IE) begin errs++; $display("FAIL grst_status1: got %h want %h", q, IE); end
        checks++; if (b0.irq !== 1'b0) begin errs++; $display("FAIL grst_irq: got %b want 0", b0.irq); end
    endtask

    task automatic test_shadow;
        logic [31:0] q;
        wr(1, 4'h1, 32'h0);
        @(negedge clk);
        force dut40.g_sec[0].time_q = 40'hFF_FFFF_FFFF;
        drive(1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0);
        #1 release dut40.g_sec[0].time_q;
        @(posedge clk);
        #1 q = b1.readdata;
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        checks++; if (q !== 32'hFFFF_FFFF) begin errs++; $display("FAIL shadow_low: got %h want ffffffff", q); end
        rd(1, 4'h1, q);
        checks++; if (q !== 32'hFF) begin errs++; $display("FAIL shadow_high: got %h want ff", q); end
        rd(1, 4'h0, q);
        checks++; if (q !== 32'd1) begin errs++; $display("FAIL shadow_live: got %h want 1", q); end
        rd(1, 4'h3, q);
        checks++; if (q !== 32'h3) begin errs++; $display("FAIL shadow_tovf: got %h want 3", q); end
        rd(1, 4'h1, q);
        checks++; if (q !== 32'h0) begin errs++; $display("FAIL shadow_relatch: got %h want 0", q); end
    endtask

    task automatic test_overflow;
        logic [31:0] q;
        wr(2, 4'h1, 32'h0);
        wr(2, 4'hB, 32'h100);
        repeat (4) wr(2, 4'h9, 32'h0);
        checks++; if (b2.irq !== 1'b0) begin errs++; $display("FAIL ovf_irq_lag: got %b want 0", b2.irq); end
        rd(2, 4'hB, q);
        checks++; if (q !== (IE | 32'h5)) begin errs++; $display("FAIL ovf_status: got %h want %h", q, IE | 32'h5); end
        checks++; if (b2.irq !== IRQ) begin errs++; $display("FAIL ovf_irq: got %b want %b", b2.irq, IRQ); end
        rd(2, 4'hA, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL ovf_event: got %0d want 0", q); end
        wr(2, 4'hB, 32'h104);
        checks++; if (b2.irq !== IRQ) begin errs++; $display("FAIL ovf_irq_hold: got %b want %b", b2.irq, IRQ); end
        rd(2, 4'hB, q);
        checks++; if (q !== (IE | 32'h1)) begin errs++; $display("FAIL ovf_w1c: got %h want %h", q, IE | 32'h1); end
        checks++; if (b2.irq !== 1'b0) begin errs++; $display("FAIL ovf_irq_clr: got %b want 0", b2.irq); end
        rd(2, 4'hC, q);
        checks++; if (q !== 32'd0) begin errs++; $display("FAIL ovf_nosec: got %h want 0", q); end
    endtask

    task automatic test_async_reset;
        logic [31:0] q;
        wr(0, 4'h1, 32'h0);
        repeat (4) wr(2, 4'h9, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (b0.readdata === 32'h0) begin errs++; $display("FAIL arst_pre_count: got %h want nonzero", b0.readdata); end
        checks++; if (b2.irq !== IRQ) begin errs++; $display("FAIL arst_pre_irq: got %b want %b", b2.irq, IRQ); end
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++; if (rdata(d) !== 32'h0) begin errs++; $display("FAIL arst_rdata%0d: got %h want 0", d, rdata(d)); end
            checks++; if (irqv(d) !== 1'b0) begin errs++; $display("FAIL arst_irq%0d: got %b want 0", d, irqv(d)); end
        end
        @(negedge clk) reset_n = 1'b1;
        rd(0, 4'h0, q);
        checks++; if (q !== 32'h0) begin errs++; $display("FAIL arst_time: got %h want 0", q); end
        rd(0, 4'h2, q);
        checks++; if (q !== 32'h0) begin errs++; $display("FAIL arst_event: got %h want 0", q); end
        rd(2, 4'hB, q);
        checks++; if (q !== 32'h0) begin errs++; $display("FAIL arst_status2: got %h want 0", q); end
        repeat (5) @(posedge clk);
        rd(0, 4'h0, q);
        checks++; if (q !== 32'h0) begin errs++; $display("FAIL arst_nogo: got %h want 0", q); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] q;
        wr(0, 4'h1, 32'h0);
        wr(0, 4'h2, 32'hFFFF_FFFF);
        rd(0, 4'h0, q);
        checks++; if (q !== 32'd1) begin errs++; $display("FAIL b2b_time1: got %0d want 1", q); end
        rd(0, 4'h0, q);
        checks++; if (q !== 32'd2) begin errs++; $display("FAIL b2b_time2: got %0d want 2", q); end
        rd(0, 4'h2, q);
        checks++; if (q !== 32'd1) begin errs++; $display("FAIL b2b_event: got %0d want 1", q); end
        op(0, 1'b1, 1'b1, 4'h0, 32'h0, q);
        checks++; if (q !== 32'd4) begin errs++; $display("FAIL b2b_wr_rd: got %0d want 4", q); end
        rd(0, 4'h3, q);
        checks++; if (q !== 32'h0) begin errs++; $display("FAIL b2b_stopped: got %h want 0", q); end
        rd(0, 4'h0, q);
        checks++; if (q !== 32'd5) begin errs++; $display("FAIL b2b_final: got %0d want 5", q); end
    endtask

    initial begin
        test_reset;
        test_count;
        test_gate;
        test_global_reset;
        test_shadow;
        test_overflow;
        test_async_reset;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
